// File: rtl/tc_timed.sv
// -----------------------------------------------------------------------------
// tc_timed -- N-approach traffic-light controller with timed phases.
//
// Serves approaches one at a time through GREEN -> YELLOW -> ALLRED. Green
// holds for MIN_GREEN..MAX_GREEN cycles depending on demand on the served
// approach. Yellow and all-red are fixed counted intervals; all-red is omitted
// when ALLRED_CYC is 0. With SKIP_IDLE set, the next green goes to the next
// approach (in round-robin order) that has a vehicle waiting.
//
// Ports:
//   CLK    in   1          system clock, rising edge
//   R      in   1          reset, asynchronous, active-high
//   T      in   N          vehicle sensor per approach (1 = vehicle present)
//   L      out  3N         lamps, L[3i+2:3i] = approach i: 100 G, 010 Y, 001 R
//   PHASE  out  clog2(N)   index of the approach currently served
//   STATE  out  2          00 GREEN, 01 YELLOW, 10 ALLRED
//
// All outputs come straight from registers; T never reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module tc_timed #(
   parameter int N          = 2,
   parameter int MIN_GREEN  = 8,
   parameter int MAX_GREEN  = 32,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 1,
   parameter int SKIP_IDLE  = 1
) (
   input  logic                   CLK,
   input  logic                   R,
   input  logic [N-1:0]           T,
   output logic [3*N-1:0]         L,
   output logic [$clog2(N)-1:0]   PHASE,
   output logic [1:0]             STATE
);

   localparam int PW      = $clog2(N);
   localparam int CNT_A   = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
   localparam int CNT_MAX = (CNT_A > ALLRED_CYC) ? CNT_A : ALLRED_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // Terminal counts: each interval ends on the edge where cnt equals its
   // length minus one.
   localparam logic [CW-1:0] C_MIN_LAST = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] C_MAX_LAST = CW'(MAX_GREEN - 1);
   localparam logic [CW-1:0] C_YEL_LAST = CW'(YELLOW_CYC - 1);
   localparam logic [CW-1:0] C_AR_LAST  = CW'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
   localparam logic [PW-1:0] C_LAST_IDX = PW'(N - 1);

   typedef enum logic [1:0] {
      S_GREEN  = 2'b00,
      S_YELLOW = 2'b01,
      S_ALLRED = 2'b10
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_cur;
   logic [CW-1:0]    r_cnt;
   logic [3*N-1:0]   r_lamp;

   logic [PW-1:0]    w_succ;
   logic [PW-1:0]    w_next;
   logic [PW-1:0]    w_cand;
   logic             w_found;
   logic             w_green_exit;

   // Lamp vector for a given state with approach idx being served; every
   // other approach is always red, which is what keeps the safety invariant.
   function automatic logic [3*N-1:0] f_lamps(input state_t st, input logic [PW-1:0] idx);
      logic [3*N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (PW'(i) == idx) begin
            case (st)
               S_GREEN:  v[3*i +: 3] = 3'b100;
               S_YELLOW: v[3*i +: 3] = 3'b010;
               default:  v[3*i +: 3] = 3'b001;
            endcase
         end else begin
            v[3*i +: 3] = 3'b001;
         end
      end
      return v;
   endfunction

   // Next approach to serve. The search starts at cur+1 and never considers
   // cur itself, so one approach never gets two greens in a row; with no
   // demand elsewhere it falls back to plain round-robin.
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_succ  = (r_cur == C_LAST_IDX) ? '0 : r_cur + 1'b1;
      w_next  = w_succ;
      w_cand  = '0;
      w_found = 1'b0;
      if (SKIP_IDLE != 0) begin
         for (int k = 1; k < N; k++) begin
            w_cand = PW'((int'(r_cur) + k) % N);
            if (!w_found && T[w_cand]) begin
               w_next  = w_cand;
               w_found = 1'b1;
            end
         end
      end
   end

   // Demand loss only counts once the minimum has been served; the maximum
   // forces an exit regardless of demand, and both together give one exit.
   assign w_green_exit = ((r_cnt >= C_MIN_LAST) && !T[r_cur]) || (r_cnt == C_MAX_LAST);

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         // NOTE: state registers use non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         r_state <= S_GREEN;
         r_cur   <= '0;
         r_cnt   <= '0;
         r_lamp  <= f_lamps(S_GREEN, '0);
      end else begin
         case (r_state)
            S_GREEN: begin
               if (w_green_exit) begin
                  r_state <= S_YELLOW;
                  r_cnt   <= '0;
                  r_lamp  <= f_lamps(S_YELLOW, r_cur);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_YELLOW: begin
               if (r_cnt == C_YEL_LAST) begin
                  r_cnt <= '0;
                  if (ALLRED_CYC > 0) begin
                     r_state <= S_ALLRED;
                     r_lamp  <= f_lamps(S_ALLRED, r_cur);
                  end else begin
                     // No clearance interval: hand over straight to the next green.
                     r_state <= S_GREEN;
                     r_cur   <= w_next;
                     r_lamp  <= f_lamps(S_GREEN, w_next);
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_ALLRED: begin
               if (r_cnt == C_AR_LAST) begin
                  r_state <= S_GREEN;
                  r_cur   <= w_next;
                  r_cnt   <= '0;
                  r_lamp  <= f_lamps(S_GREEN, w_next);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               // Unused encoding: fall back to an all-red clearance.
               r_state <= S_ALLRED;
               r_cnt   <= '0;
               r_lamp  <= f_lamps(S_ALLRED, r_cur);
            end
         endcase
      end
   end

   assign L     = r_lamp;
   assign PHASE = r_cur;
   assign STATE = r_state;

endmodule

// File: tb/tb_tc_timed.sv
// -----------------------------------------------------------------------------
// tb_tc_timed -- testbench for tc_timed.
//
// Three instances share clock, reset and sensors (N=3, MIN 4, MAX 8, Y 2):
//   u_dut : ALLRED_CYC=1, SKIP_IDLE=1
//   u_rr  : ALLRED_CYC=1, SKIP_IDLE=0
//   u_nar : ALLRED_CYC=0, SKIP_IDLE=1
// Expected per-cycle lamp/phase/state values are queued per instance when the
// stimulus is applied and popped on each falling edge.
// -----------------------------------------------------------------------------
module tb_tc_timed;

   localparam logic [1:0] G  = 2'b00;
   localparam logic [1:0] Y  = 2'b01;
   localparam logic [1:0] AR = 2'b10;

   logic       CLK = 1'b0;
   logic       R;
   logic [2:0] T;

   logic [8:0] l_a, l_b, l_c;
   logic [1:0] ph_a, ph_b, ph_c;
   logic [1:0] st_a, st_b, st_c;

   always #5 CLK = ~CLK;

   tc_timed #(.N(3), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_IDLE(1))
      u_dut (.CLK(CLK), .R(R), .T(T), .L(l_a), .PHASE(ph_a), .STATE(st_a));

   tc_timed #(.N(3), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_IDLE(0))
      u_rr (.CLK(CLK), .R(R), .T(T), .L(l_b), .PHASE(ph_b), .STATE(st_b));

   tc_timed #(.N(3), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(0), .SKIP_IDLE(1))
      u_nar (.CLK(CLK), .R(R), .T(T), .L(l_c), .PHASE(ph_c), .STATE(st_c));

   typedef struct {
      logic [8:0] lamp;
      logic [1:0] ph;
      logic [1:0] st;
      string      tag;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Lamp encoding from the interface description.
   function automatic logic [8:0] lamps(input logic [1:0] st, input int ph);
      logic [8:0] v;
      v = 9'b001_001_001;
      case (st)
         G:       v[3*ph +: 3] = 3'b100;
         Y:       v[3*ph +: 3] = 3'b010;
         default: v[3*ph +: 3] = 3'b001;
      endcase
      return v;
   endfunction

   function automatic int nonred(input logic [8:0] l);
      int n;
      n = 0;
      for (int i = 0; i < 3; i++)
         if (l[3*i +: 3] != 3'b001) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input int ph, input logic [1:0] st, input int n, input string tag);
      exp_t e;
      e.lamp = lamps(st, ph);
      e.ph   = 2'(ph);
      e.st   = st;
      e.tag  = tag;
      repeat (n) begin
         case (d)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
         endcase
      end
   endtask

   task automatic push_run(input int d, input int ph, input int g, input int y, input int ar,
                           input string tag);
      push(d, ph, G, g, tag);
      push(d, ph, Y, y, tag);
      push(d, ph, AR, ar, tag);
   endtask

   task automatic get_out(input int d, output logic [8:0] l, output logic [1:0] ph,
                          output logic [1:0] st);
      case (d)
         0:       begin l = l_a; ph = ph_a; st = st_a; end
         1:       begin l = l_b; ph = ph_b; st = st_b; end
         default: begin l = l_c; ph = ph_c; st = st_c; end
      endcase
   endtask

   // Advance n cycles; on each falling edge compare every instance that has
   // an expectation queued against its outputs.
   task automatic run(input int n);
      exp_t       e;
      bit         have;
      logic [8:0] l;
      logic [1:0] ph, st;
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         for (int d = 0; d < 3; d++) begin
            have = 1'b0;
            case (d)
               0:       if (q_a.size() != 0) begin e = q_a.pop_front(); have = 1'b1; end
               1:       if (q_b.size() != 0) begin e = q_b.pop_front(); have = 1'b1; end
               default: if (q_c.size() != 0) begin e = q_c.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
               get_out(d, l, ph, st);
               check($sformatf("%s.d%0d.L@%0d", e.tag, d, k), 32'(l), 32'(e.lamp));
               check($sformatf("%s.d%0d.PHASE@%0d", e.tag, d, k), 32'(ph), 32'(e.ph));
               check($sformatf("%s.d%0d.STATE@%0d", e.tag, d, k), 32'(st), 32'(e.st));
            end
         end
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".L"}, 32'(l_a), 32'(9'b001_001_100));
      check({tag, ".PHASE"}, 32'(ph_a), 32'd0);
      check({tag, ".STATE"}, 32'(st_a), 32'd0);
   endtask

   int         run_len [3];
   bit         started [3];
   logic [1:0] prev_st [3];

   initial begin
      logic [8:0] l;
      logic [1:0] ph, st;

      R = 1'b1;
      T = 3'b000;
      repeat (2) @(negedge CLK);
      check_reset("por");

      // Minimum green: no demand on approach 0; approach 1 keeps demand and
      // runs to maximum, then 2 is next.
      T = 3'b110;
      R = 1'b0;
      check_reset("release");
      for (int d = 0; d < 2; d++) begin
         push_run(d, 0, 3, 2, 1, "min_green");
         push_run(d, 1, 8, 2, 1, "min_green");
         push(d, 2, G, 1, "min_green");
      end
      run(18);

      // Skip idle: only approach 2 has demand.
      @(negedge CLK); R = 1'b1;
      @(negedge CLK); T = 3'b100; R = 1'b0;
      push_run(0, 0, 3, 2, 1, "skip");
      push(0, 2, G, 2, "skip");
      push_run(1, 0, 3, 2, 1, "rr");
      push(1, 1, G, 2, "rr");
      run(8);

      // Maximum green with demand everywhere; u_nar shows the direct
      // yellow-to-green handover. Reset is pulsed during approach 2's yellow.
      @(negedge CLK); R = 1'b1;
      @(negedge CLK); T = 3'b111; R = 1'b0;
      for (int d = 0; d < 2; d++) begin
         push_run(d, 0, 7, 2, 1, "max_green");
         push_run(d, 1, 8, 2, 1, "max_green");
         push(d, 2, G, 8, "max_green");
         push(d, 2, Y, 1, "max_green");
      end
      push_run(2, 0, 7, 2, 0, "no_allred");
      push_run(2, 1, 8, 2, 0, "no_allred");
      push_run(2, 2, 8, 2, 0, "no_allred");
      push(2, 0, G, 1, "no_allred");
      run(30);
      #2 R = 1'b1;
      #1 check_reset("async_reset");

      // Random sensors: safety invariant, legal state codes, green length.
      @(negedge CLK); R = 1'b0;
      for (int d = 0; d < 3; d++) begin
         run_len[d] = 0;
         started[d] = 1'b0;
         prev_st[d] = G;
      end
      for (int c = 0; c < 10000; c++) begin
         @(negedge CLK);
         for (int d = 0; d < 3; d++) begin
            get_out(d, l, ph, st);
            check($sformatf("one_nonred.d%0d@%0d", d, c), 32'(nonred(l) <= 1), 32'd1);
            if (d == 2)
               check($sformatf("state_code.d2@%0d", c), 32'(st == G || st == Y), 32'd1);
            else
               check($sformatf("state_code.d%0d@%0d", d, c), 32'(st != 2'b11), 32'd1);
            if (st == G) begin
               if (prev_st[d] != G) begin
                  started[d] = 1'b1;
                  run_len[d] = 0;
               end
               run_len[d]++;
            end else if (prev_st[d] == G && started[d]) begin
               check($sformatf("green_len.d%0d@%0d(len=%0d)", d, c, run_len[d]),
                     32'(run_len[d] >= 4 && run_len[d] <= 8), 32'd1);
            end
            prev_st[d] = st;
         end
         T = 3'($urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
